line_burst_adapter: RTL and testbench
=====================================

Name: line_burst_adapter

Overview:
- Sits directly downstream of the eviction buffer, between its physical-memory port and the physical memory.
- Converts single-transaction 1024-bit cache-line reads and writes into 8-beat bursts of 128-bit words.
- Presents a line-wide request/response handshake upstream and a per-beat handshake downstream.
- Buffers the write line and assembles the read line internally.

Parameters:
- ADDR_WIDTH, 16, byte-address width on both sides.
- LINE_WIDTH, 1024, upstream line width in bits.
- BEAT_WIDTH, 128, downstream beat width in bits; BEATS = LINE_WIDTH/BEAT_WIDTH = 8.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- pmem_read  in  1  line read request; held until pmem_resp.
- pmem_write  in  1  line write request; held until pmem_resp.
- pmem_addr  in  ADDR_WIDTH  line address; low 7 bits ignored.
- pmem_wdata  in  LINE_WIDTH  write line.
- pmem_resp  out  1  one-cycle completion pulse.
- pmem_rdata  out  LINE_WIDTH  assembled read line; valid with pmem_resp, held afterwards.
- mem_read  out  1  beat read request.
- mem_write  out  1  beat write request.
- mem_addr  out  ADDR_WIDTH  beat address.
- mem_wdata  out  BEAT_WIDTH  beat write data.
- mem_rdata  in  BEAT_WIDTH  beat read data; valid with mem_resp.
- mem_resp  in  1  beat complete.

Behaviour:
- Reset:
  - state=IDLE, beat counter=0.
  - pmem_resp, mem_read, mem_write=0.
  - mem_addr, mem_wdata, pmem_rdata and the latched address/line registers=0.
- States: IDLE, READ_BURST, WRITE_BURST, DONE.
- IDLE:
  - pmem_write=1 → latch the line-aligned address {pmem_addr[15:7],7'b0} and pmem_wdata, counter=0, go to WRITE_BURST.
  - Else pmem_read=1 → latch the address, counter=0, go to READ_BURST.
  - Both asserted: write takes priority; the read is served after the write completes, provided it is still held.
  - mem_resp is ignored in IDLE and DONE.
- Beat address: mem_addr = {line_addr[15:7], counter[2:0], 4'b0000}.
- READ_BURST:
  - mem_read=1 continuously, including wait cycles.
  - On mem_resp, store mem_rdata into pmem_rdata[counter*128 +: 128], then counter++.
  - mem_resp on counter=7 → go to DONE.
- WRITE_BURST:
  - mem_write=1 continuously.
  - mem_wdata = latched_line[counter*128 +: 128].
  - On mem_resp, counter++; mem_resp on counter=7 → go to DONE.
- Beat ordering: beat 0 is the least-significant 128 bits; beats issue strictly in order 0..7.
- DONE:
  - pmem_resp=1 for exactly one cycle; mem_read/mem_write=0; go to IDLE.
  - The requester deasserts pmem_read/pmem_write in the following cycle.
  - A request present in IDLE after DONE is treated as a new transaction.
- Counter: 3-bit; wraps 7→0 at the end of a burst and is cleared on entry to a burst.
- Latency: request seen in IDLE at cycle T, zero-wait memory (mem_resp every cycle) → beats complete T+1..T+8, pmem_resp at T+9. Each wait cycle adds one.
- Upstream inputs are ignored outside IDLE. pmem_addr/pmem_wdata changes mid-burst have no effect.
- pmem_rdata changes only in READ_BURST beats. It is unchanged by writes.
- Reset mid-burst:
  - Return to IDLE next edge and drop mem_read/mem_write.
  - No pmem_resp is issued.
  - Partially assembled pmem_rdata is cleared to 0.

Test Plan:
- Reset, then idle 5 cycles → all outputs 0, no mem_read/mem_write.
- Read, pmem_addr=16'h1234, memory returns beat k = {16{8'h10+k}} with zero wait:
  - mem_addr steps 16'h1200,16'h1210,…,16'h1270.
  - pmem_resp exactly 9 cycles after the request.
  - pmem_rdata[127:0]={16{8'h10}}, pmem_rdata[1023:896]={16{8'h17}}.
- Write, pmem_addr=16'h0080, pmem_wdata beat k = 128'hk repeated, memory inserts 2 wait cycles per beat:
  - mem_wdata equals beat k while counter=k.
  - mem_write stays high across waits.
  - pmem_resp at cycle 25; afterwards pmem_rdata is unchanged.
- pmem_read and pmem_write asserted together, addr 16'h0100:
  - Write burst runs first, then pmem_resp.
  - With read still held in the next cycle, the read burst starts → second pmem_resp.
- reset asserted after beat 3 of a read:
  - Next cycle state IDLE, mem_read=0, counter=0, pmem_rdata=0, no pmem_resp.
  - A subsequent read completes normally.
- Spurious mem_resp pulses in IDLE and DONE → no state change, no counter change.

Source files
------------

// File: rtl/line_burst_adapter.sv
// Line/burst adapter: turns one upstream cache-line read or write into an
// in-order burst of BEATS narrower transfers on the downstream memory port.
module line_burst_adapter #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned LINE_WIDTH = 1024,
    parameter int unsigned BEAT_WIDTH = 128
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  pmem_read,
    input  logic                  pmem_write,
    input  logic [ADDR_WIDTH-1:0] pmem_addr,
    input  logic [LINE_WIDTH-1:0] pmem_wdata,
    output logic                  pmem_resp,
    output logic [LINE_WIDTH-1:0] pmem_rdata,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [BEAT_WIDTH-1:0] mem_wdata,
    input  logic [BEAT_WIDTH-1:0] mem_rdata,
    input  logic                  mem_resp
);

    localparam int unsigned BEATS  = LINE_WIDTH / BEAT_WIDTH;
    localparam int unsigned CNT_W  = $clog2(BEATS);
    localparam int unsigned BOFF_W = $clog2(BEAT_WIDTH / 8);
    localparam int unsigned LOFF_W = CNT_W + BOFF_W;
    localparam int unsigned LA_W   = ADDR_WIDTH - LOFF_W;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        READ_BURST  = 2'd1,
        WRITE_BURST = 2'd2,
        DONE        = 2'd3
    } state_e;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [LA_W-1:0]       line_addr_q, line_addr_d;
    logic [LINE_WIDTH-1:0] line_q, line_d;
    logic [LINE_WIDTH-1:0] rdata_q, rdata_d;
    logic                  resp_q, resp_d;
    logic                  rd_q, rd_d;
    logic                  wr_q, wr_d;
    logic [ADDR_WIDTH-1:0] maddr_q, maddr_d;
    logic [BEAT_WIDTH-1:0] wdata_q, wdata_d;

    // Byte offset within a line never reaches the memory side.
    logic unused_addr_bits;
    assign unused_addr_bits = ^pmem_addr[LOFF_W-1:0];

    // Next-state, datapath and next-output decode.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        line_addr_d = line_addr_q;
        line_d      = line_q;
        rdata_d     = rdata_q;

        case (state_q)
            IDLE: begin
                // A write wins when both requests are up; a still-held read
                // is picked up after the write's completion cycle.
                if (pmem_write) begin
                    line_addr_d = pmem_addr[ADDR_WIDTH-1:LOFF_W];
                    line_d      = pmem_wdata;
                    cnt_d       = '0;
                    state_d     = WRITE_BURST;
                end else if (pmem_read) begin
                    line_addr_d = pmem_addr[ADDR_WIDTH-1:LOFF_W];
                    cnt_d       = '0;
                    state_d     = READ_BURST;
                end
            end
            READ_BURST: begin
                if (mem_resp) begin
                    rdata_d[32'(cnt_q) * BEAT_WIDTH +: BEAT_WIDTH] = mem_rdata;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_BEAT) begin
                        state_d = DONE;
                    end
                end
            end
            WRITE_BURST: begin
                if (mem_resp) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_BEAT) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are registered, so they are decoded from the next state.
        resp_d  = (state_d == DONE);
        rd_d    = (state_d == READ_BURST);
        wr_d    = (state_d == WRITE_BURST);
        maddr_d = {line_addr_d, cnt_d, BOFF_W'(0)};
        wdata_d = line_d[32'(cnt_d) * BEAT_WIDTH +: BEAT_WIDTH];
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            line_addr_q <= '0;
            line_q      <= '0;
            rdata_q     <= '0;
            resp_q      <= 1'b0;
            rd_q        <= 1'b0;
            wr_q        <= 1'b0;
            maddr_q     <= '0;
            wdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            line_addr_q <= line_addr_d;
            line_q      <= line_d;
            rdata_q     <= rdata_d;
            resp_q      <= resp_d;
            rd_q        <= rd_d;
            wr_q        <= wr_d;
            maddr_q     <= maddr_d;
            wdata_q     <= wdata_d;
        end
    end

    assign pmem_resp  = resp_q;
    assign pmem_rdata = rdata_q;
    assign mem_read   = rd_q;
    assign mem_write  = wr_q;
    assign mem_addr   = maddr_q;
    assign mem_wdata  = wdata_q;

endmodule

// File: tb/tb_line_burst_adapter.sv
// Bench for line_burst_adapter: a word-addressed memory model answers beats,
// a transaction-level model predicts addresses, data, lines and latency.
module tb_line_burst_adapter;

    localparam int unsigned AW = 16;
    localparam int unsigned LW = 1024;
    localparam int unsigned BW = 128;
    localparam int unsigned NB = LW / BW;

    logic          clk = 1'b0;
    logic          reset;
    logic          pmem_read, pmem_write;
    logic [AW-1:0] pmem_addr;
    logic [LW-1:0] pmem_wdata;
    logic          pmem_resp;
    logic [LW-1:0] pmem_rdata;
    logic          mem_read, mem_write;
    logic [AW-1:0] mem_addr;
    logic [BW-1:0] mem_wdata;
    logic [BW-1:0] mem_rdata;
    logic          mem_resp;

    always #5 clk = ~clk;

    line_burst_adapter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW), .BEAT_WIDTH(BW)) dut (
        .clk(clk), .reset(reset),
        .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_addr(pmem_addr), .pmem_wdata(pmem_wdata),
        .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_resp(mem_resp)
    );

    int n_cmp = 0;
    int n_fail = 0;

    // Memory contents, one entry per 16-byte beat.
    logic [BW-1:0] mem [4096];

    // Current transaction as the model sees it.
    bit            busy = 1'b0;
    bit            kind_wr = 1'b0;
    logic [AW-1:0] exp_base;
    logic [LW-1:0] exp_wline;
    logic [LW-1:0] exp_line;
    logic [LW-1:0] exp_rdata = '0;
    int            beat_idx = 0;
    int            waits = 0;
    int            wc = 0;
    bit            spurious = 1'b0;

    task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_line(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            for (int k = 0; k < int'(NB); k++) begin
                if (act[k*BW +: BW] !== exp[k*BW +: BW]) begin
                    $display("FAIL %s: beat %0d got %0h expected %0h (t=%0t)", name, k,
                             act[k*BW +: BW], exp[k*BW +: BW], $time);
                    break;
                end
            end
        end
    endtask

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] r;
        for (int i = 0; i < int'(LW / 32); i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Compare against the model, then act as the beat-level memory.
    always @(negedge clk) begin
        logic [AW-1:0] ea;
        mem_resp = 1'b0;
        if (!reset) begin
            check("rd_wr_exclusive", BW'(mem_read & mem_write), '0);
            if (pmem_resp) begin
                check("resp_expected", BW'(busy), BW'(1));
                check("mem_idle_in_done", BW'(mem_read | mem_write), '0);
                if (busy) begin
                    check("beats_at_resp", BW'(beat_idx), BW'(NB));
                    if (kind_wr) begin
                        check_line("rdata_kept_on_write", pmem_rdata, exp_rdata);
                    end else begin
                        check_line("rdata_line", pmem_rdata, exp_line);
                        exp_rdata = exp_line;
                    end
                    busy = 1'b0;
                end
            end else if (busy && beat_idx < int'(NB)) begin
                check("mem_read", BW'(mem_read), BW'(!kind_wr));
                check("mem_write", BW'(mem_write), BW'(kind_wr));
                ea = {exp_base[AW-1:7], 3'(beat_idx), 4'b0000};
                check("mem_addr", BW'(mem_addr), BW'(ea));
                if (kind_wr) check("mem_wdata", mem_wdata, exp_wline[beat_idx*BW +: BW]);
            end else begin
                check("mem_read_idle", BW'(mem_read), '0);
                check("mem_write_idle", BW'(mem_write), '0);
                if (!busy) check_line("rdata_hold", pmem_rdata, exp_rdata);
            end

            if (mem_read || mem_write) begin
                if (wc >= waits) begin
                    wc = 0;
                    mem_resp = 1'b1;
                    if (mem_write) mem[mem_addr[15:4]] = mem_wdata;
                    else mem_rdata = mem[mem_addr[15:4]];
                    beat_idx++;
                end else begin
                    wc++;
                end
            end else if (spurious) begin
                mem_resp  = 1'($urandom);
                mem_rdata = {$urandom, $urandom, $urandom, $urandom};
            end
        end
    end

    task automatic start_model(input bit wr, input logic [AW-1:0] addr, input logic [LW-1:0] wd);
        kind_wr   = wr;
        exp_base  = {addr[AW-1:7], 7'b0};
        exp_wline = wd;
        beat_idx  = 0;
        wc        = 0;
        for (int k = 0; k < int'(NB); k++)
            exp_line[k*BW +: BW] = mem[int'(exp_base[AW-1:4]) + k];
        busy = 1'b1;
    endtask

    task automatic wait_resp(output int lat);
        lat = 1;
        while (!pmem_resp) begin
            if (lat >= 400) begin
                n_cmp++;
                n_fail++;
                $display("FAIL resp_timeout: no pmem_resp after %0d cycles", lat);
                busy = 1'b0;
                return;
            end
            @(posedge clk); #1;
            lat++;
        end
    endtask

    // One upstream transaction; a read+write pair returns both latencies.
    task automatic txn(input bit rd, input bit wr, input logic [AW-1:0] addr,
                       input logic [LW-1:0] wd, input int w, output int lat1, output int lat2);
        waits = w;
        pmem_read = rd; pmem_write = wr; pmem_addr = addr; pmem_wdata = wd;
        lat2 = 0;
        @(posedge clk); #1;
        start_model(wr, addr, wd);
        pmem_addr  = AW'($urandom);
        pmem_wdata = rand_line();
        wait_resp(lat1);
        @(posedge clk); #1;
        pmem_write = 1'b0;
        pmem_addr  = addr;
        if (rd && wr) begin
            @(posedge clk); #1;
            start_model(1'b0, addr, wd);
            wait_resp(lat2);
            @(posedge clk); #1;
        end
        pmem_read = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_pmem_resp"}, BW'(pmem_resp), '0);
        check({tag, "_mem_read"}, BW'(mem_read), '0);
        check({tag, "_mem_write"}, BW'(mem_write), '0);
        check({tag, "_mem_addr"}, BW'(mem_addr), '0);
        check({tag, "_mem_wdata"}, mem_wdata, '0);
        check_line({tag, "_pmem_rdata"}, pmem_rdata, '0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int l1, l2;
        logic [LW-1:0] wd, line_a;
        logic [AW-1:0] a;

        reset = 1'b1; pmem_read = 1'b0; pmem_write = 1'b0;
        pmem_addr = '0; pmem_wdata = '0; mem_rdata = '0; mem_resp = 1'b0;
        for (int i = 0; i < 4096; i++) mem[i] = {$urandom, $urandom, $urandom, $urandom};

        // Reset state, then five idle cycles.
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        reset = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check_reset_outputs("idle");

        // Read 0x1234, zero-wait memory with known beats.
        for (int k = 0; k < int'(NB); k++) mem[12'h120 + k] = {16{8'(8'h10 + k)}};
        txn(1'b1, 1'b0, 16'h1234, rand_line(), 0, l1, l2);
        check("read_latency", BW'(l1), BW'(9));
        check("read_beat0", pmem_rdata[127:0], {16{8'h10}});
        check("read_beat7", pmem_rdata[1023:896], {16{8'h17}});
        line_a = pmem_rdata;

        // Write 0x0080, two wait cycles per beat.
        for (int k = 0; k < int'(NB); k++) wd[k*BW +: BW] = {32{4'(k)}};
        txn(1'b0, 1'b1, 16'h0080, wd, 2, l1, l2);
        check("write_latency", BW'(l1), BW'(25));
        check("write_mem_beat0", mem[12'h008], {32{4'h0}});
        check("write_mem_beat7", mem[12'h00f], {32{4'h7}});
        check_line("write_rdata_unchanged", pmem_rdata, line_a);

        // Read and write together: write first, then the held read.
        wd = rand_line();
        txn(1'b1, 1'b1, 16'h0100, wd, 0, l1, l2);
        check("both_write_latency", BW'(l1), BW'(9));
        check("both_read_latency", BW'(l2), BW'(9));
        check_line("both_read_back", pmem_rdata, wd);

        // Reset after four beats of a read.
        waits = 0;
        pmem_read = 1'b1; pmem_addr = 16'h1234;
        @(posedge clk); #1;
        start_model(1'b0, 16'h1234, '0);
        l1 = 0;
        while (beat_idx < 4 && l1 < 100) begin
            @(posedge clk); #1;
            l1++;
        end
        reset = 1'b1; busy = 1'b0; pmem_read = 1'b0;
        @(posedge clk); #1;
        check_reset_outputs("midreset");
        exp_rdata = '0;
        reset = 1'b0;
        @(posedge clk); #1;
        txn(1'b1, 1'b0, 16'h1200, '0, 0, l1, l2);
        check("post_reset_latency", BW'(l1), BW'(9));
        check("post_reset_beat0", pmem_rdata[127:0], {16{8'h10}});

        // Spurious memory responses while idle or completing.
        spurious = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        txn(1'b1, 1'b0, 16'h0080, '0, 1, l1, l2);
        check("spurious_latency", BW'(l1), BW'(17));
        check("spurious_read_beat3", pmem_rdata[511:384], {32{4'h3}});

        // Randomized traffic over a small set of lines.
        for (int n = 0; n < 30; n++) begin
            int kind, w;
            kind = int'($urandom_range(0, 2));
            w    = int'($urandom_range(0, 3));
            a    = AW'(($urandom_range(0, 15) << 7) | $urandom_range(0, 127));
            wd   = rand_line();
            txn(kind != 1, kind != 0, a, wd, w, l1, l2);
            check("rand_latency", BW'(l1), BW'(1 + 8 * (w + 1)));
            if (kind == 2) begin
                check("rand_latency2", BW'(l2), BW'(1 + 8 * (w + 1)));
                check_line("rand_both_back", pmem_rdata, wd);
            end
            if ($urandom_range(0, 3) == 0) repeat (int'($urandom_range(1, 4))) @(posedge clk);
            #1;
        end
        spurious = 1'b0;
        repeat (3) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
